// File: rtl/axi4_lite_cmd_master.sv
// AXI4-Lite master that turns one command word into exactly one read or write
// transaction and returns one response pulse, with a per-transaction timeout.
module axi4_lite_cmd_master #(
  parameter int G_ADDR_WIDTH = 32,
  parameter int G_DATA_WIDTH = 32,
  parameter int G_TIMEOUT    = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_rnw,
  input  logic [G_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [G_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [G_DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                      rsp_valid,
  output logic [G_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                rsp_resp,
  output logic                      rsp_timeout,
  output logic [G_ADDR_WIDTH-1:0]   m_awaddr,
  output logic [2:0]                m_awprot,
  output logic                      m_awvalid,
  input  logic                      m_awready,
  output logic [G_DATA_WIDTH-1:0]   m_wdata,
  output logic [G_DATA_WIDTH/8-1:0] m_wstrb,
  output logic                      m_wvalid,
  input  logic                      m_wready,
  input  logic [1:0]                m_bresp,
  input  logic                      m_bvalid,
  output logic                      m_bready,
  output logic [G_ADDR_WIDTH-1:0]   m_araddr,
  output logic [2:0]                m_arprot,
  output logic                      m_arvalid,
  input  logic                      m_arready,
  input  logic [G_DATA_WIDTH-1:0]   m_rdata,
  input  logic [1:0]                m_rresp,
  input  logic                      m_rvalid,
  output logic                      m_rready,
  output logic [2:0]                dbg_state
);

  localparam int CW = $clog2(G_TIMEOUT);
  localparam int SW = G_DATA_WIDTH / 8;
  localparam logic [CW-1:0] CNT_MAX = CW'(G_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_REQ  = 3'd1,
    S_WR_RESP = 3'd2,
    S_RD_REQ  = 3'd3,
    S_RD_RESP = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  // Handshake rule on every channel: a transfer happens on a rising edge where
  // valid & ready are both 1; a valid, once raised, holds until that transfer
  // (except on timeout abort), and ready may be raised at any time.
  state_t                    state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [G_ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [G_DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [SW-1:0]             wstrb_q, wstrb_d;
  logic                      awvalid_q, awvalid_d;
  logic                      wvalid_q, wvalid_d;
  logic                      arvalid_q, arvalid_d;
  logic                      aw_done_q, aw_done_d;
  logic                      w_done_q, w_done_d;
  logic [G_DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [1:0]                resp_q, resp_d;
  logic                      tout_q, tout_d;

  logic aw_hs, w_hs, ar_hs, busy, complete, abort;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    arvalid_d = arvalid_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    rdata_d   = rdata_q;
    resp_d    = resp_q;
    tout_d    = tout_q;

    aw_hs    = awvalid_q & m_awready;
    w_hs     = wvalid_q & m_wready;
    ar_hs    = arvalid_q & m_arready;
    busy     = (state_q != S_IDLE) && (state_q != S_DONE);
    complete = ((state_q == S_WR_RESP) && m_bvalid) ||
               ((state_q == S_RD_RESP) && m_rvalid);
    // Only the final response beat beats the timeout; address progress does not.
    abort    = busy && (cnt_q == CNT_MAX) && !complete;

    if (busy && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          wstrb_d = cmd_wstrb;
          cnt_d   = '0;
          if (cmd_rnw) begin
            arvalid_d = 1'b1;
            state_d   = S_RD_REQ;
          end else begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            state_d   = S_WR_REQ;
          end
        end
      end
      S_WR_REQ: begin
        if (aw_hs) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_hs) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
          state_d = S_WR_RESP;
        end
      end
      S_WR_RESP: begin
        if (m_bvalid) begin
          rdata_d = '0;
          resp_d  = m_bresp;
          tout_d  = 1'b0;
          state_d = S_DONE;
        end
      end
      S_RD_REQ: begin
        if (ar_hs) begin
          arvalid_d = 1'b0;
          state_d   = S_RD_RESP;
        end
      end
      S_RD_RESP: begin
        if (m_rvalid) begin
          rdata_d = m_rdata;
          resp_d  = m_rresp;
          tout_d  = 1'b0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // The slave is presumed hung: withdraw every request and report SLVERR.
    if (abort) begin
      awvalid_d = 1'b0;
      wvalid_d  = 1'b0;
      arvalid_d = 1'b0;
      rdata_d   = '0;
      resp_d    = 2'b10;
      tout_d    = 1'b1;
      state_d   = S_DONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rdata_q   <= '0;
      resp_q    <= '0;
      tout_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      arvalid_q <= arvalid_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
      tout_q    <= tout_d;
    end
  end

  assign cmd_ready   = (state_q == S_IDLE) && !rst;
  assign rsp_valid   = (state_q == S_DONE);
  assign rsp_rdata   = rdata_q;
  assign rsp_resp    = resp_q;
  assign rsp_timeout = tout_q;
  assign m_awaddr    = addr_q;
  assign m_awprot    = 3'b000;
  assign m_awvalid   = awvalid_q;
  assign m_wdata     = wdata_q;
  assign m_wstrb     = wstrb_q;
  assign m_wvalid    = wvalid_q;
  assign m_bready    = (state_q == S_WR_RESP);
  assign m_araddr    = addr_q;
  assign m_arprot    = 3'b000;
  assign m_arvalid   = arvalid_q;
  assign m_rready    = (state_q == S_RD_RESP);
  assign dbg_state   = state_q;

endmodule
